// File: rtl/ram_bist_ctrl_if.sv
// Single-port RAM bus between the BIST initiator and the RAM under test.
// The master drives write enable, address and write data. The slave returns read data.
interface ram_bist_ctrl_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 8
);
    logic          write_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    modport master (
        output write_en,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_en,
        input  addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// RAM write-then-readback self-test controller.
// A start pulse fills every address with SEED ^ addr, then reads each address back and compares it.
// When the test ends, it reports pass/fail, the first failing address and a saturating error count.
// Optional macro RAM_BIST_INV_PASS_EN adds a second write/read pass using the inverted pattern,
// so that every bit is exercised in both polarities.
module ram_bist_ctrl #(
    parameter int unsigned   AW     = 3,
    parameter int unsigned   DW     = 8,
    parameter logic [DW-1:0] SEED   = 8'hA5,
    parameter int unsigned   RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ram_bist_ctrl_if.master       ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [AW-1:0]         fail_addr,
    output logic [AW:0]           err_count
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [AW:0] ERR_MAX = {1'b1, {AW{1'b0}}};

    state_t        state, state_d;
    logic [AW:0]   addr_cnt, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [AW-1:0] fail_q, fail_d;
    logic [AW:0]   err_q, err_d;

`ifdef RAM_BIST_INV_PASS_EN
    logic          inv_q, inv_d;
`else
    logic          inv_q;
    assign inv_q = 1'b0;
`endif

    logic          issue;
    logic          last_addr;
    logic          cmp_valid;
    logic [DW-1:0] cmp_exp;
    logic [AW-1:0] cmp_addr;
    logic          mismatch;
    logic [AW:0]   err_after;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic inv);
        logic [DW-1:0] p;
        p = SEED ^ DW'(a);
        return inv ? ~p : p;
    endfunction

    // The counter's extra top bit can only be set if the count overruns, which also forces
    // the end of a pass, so the counter never wraps past the depth.
    assign last_addr = (&addr_cnt[AW-1:0]) | addr_cnt[AW];
    assign issue     = (state == READ);

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign cmp_valid = issue;
            assign cmp_exp   = pattern(addr_cnt[AW-1:0], inv_q);
            assign cmp_addr  = addr_cnt[AW-1:0];
        end else begin : g_lat1
            // Delay the expected value and its address by one stage to line up with registered read data
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cmp_valid <= 1'b0;
                    cmp_exp   <= '0;
                    cmp_addr  <= '0;
                end else begin
                    cmp_valid <= issue;
                    cmp_exp   <= pattern(addr_cnt[AW-1:0], inv_q);
                    cmp_addr  <= addr_cnt[AW-1:0];
                end
            end
        end
    endgenerate

    assign mismatch  = cmp_valid && (ram.read_data != cmp_exp);
    assign err_after = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

    // Next-state, next-output and result bookkeeping for the test sequence
    always_comb begin
        state_d = state;
        addr_d  = addr_cnt;
        we_d    = we_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_after;
`ifdef RAM_BIST_INV_PASS_EN
        inv_d   = inv_q;
`endif

        if (mismatch && (err_q == '0)) begin
            fail_d = cmp_addr;
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    wdata_d = pattern('0, 1'b0);
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = '0;
                    err_d   = '0;
`ifdef RAM_BIST_INV_PASS_EN
                    inv_d   = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (last_addr) begin
                    state_d = READ;
                    addr_d  = '0;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end else begin
                    addr_d  = addr_cnt + 1'b1;
                    wdata_d = pattern(addr_d[AW-1:0], inv_q);
                end
            end
            READ: begin
                if (last_addr) begin
                    addr_d = '0;
`ifdef RAM_BIST_INV_PASS_EN
                    if (!inv_q) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        wdata_d = pattern('0, 1'b1);
                        inv_d   = 1'b1;
                    end else
`endif
                    if (RD_LAT == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    addr_d = addr_cnt + 1'b1;
                end
            end
            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_d == '0);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            addr_cnt <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= '0;
            err_q    <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            addr_cnt <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
`ifdef RAM_BIST_INV_PASS_EN
            inv_q    <= inv_d;
`endif
        end
    end

    assign ram.write_en   = we_q;
    assign ram.addr       = addr_cnt[AW-1:0];
    assign ram.write_data = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_addr      = fail_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed testbench for ram_bist_ctrl.
// DUT a uses RD_LAT=1 against a registered-read RAM model with per-address fault injection.
// DUT b uses RD_LAT=0 against a combinational-read RAM model.
// Expected values follow RAM_BIST_INV_PASS_EN when it is defined.
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic       busy_a, done_a, pass_a;
    logic       busy_b, done_b, pass_b;
    logic [2:0] fail_a, fail_b;
    logic [3:0] err_a, err_b;

    ram_bist_ctrl_if #(.AW(3), .DW(8)) bus_a ();
    ram_bist_ctrl_if #(.AW(3), .DW(8)) bus_b ();

    ram_bist_ctrl #(.AW(3), .DW(8), .SEED(8'hA5), .RD_LAT(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .ram       (bus_a),
        .busy      (busy_a),
        .done      (done_a),
        .pass      (pass_a),
        .fail_addr (fail_a),
        .err_count (err_a)
    );

    ram_bist_ctrl #(.AW(3), .DW(8), .SEED(8'hA5), .RD_LAT(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .ram       (bus_b),
        .busy      (busy_b),
        .done      (done_b),
        .pass      (pass_b),
        .fail_addr (fail_b),
        .err_count (err_b)
    );

`ifdef RAM_BIST_INV_PASS_EN
    localparam int         LAT_A     = 34;
    localparam int         LAT_B     = 33;
    localparam logic       PASS_BIT0 = 1'b0;
    localparam logic [3:0] ERR_BIT0  = 4'd1;
    localparam logic [2:0] FAIL_BIT0 = 3'd3;
    localparam logic [3:0] ERR_MULTI = 4'd4;
`else
    localparam int         LAT_A     = 18;
    localparam int         LAT_B     = 17;
    localparam logic       PASS_BIT0 = 1'b1;
    localparam logic [3:0] ERR_BIT0  = 4'd0;
    localparam logic [2:0] FAIL_BIT0 = 3'd0;
    localparam logic [3:0] ERR_MULTI = 4'd2;
`endif

    logic [7:0] write_tbl [8] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};

    // RAM model a: registered read, with stuck-at-0 and bit-flip masks applied on readback
    logic [7:0] mem_a [8];
    logic [7:0] stuck0 [8];
    logic [7:0] flip [8];
    logic [7:0] rq_a;
    logic [2:0] ra_a;

    always @(posedge clk) begin
        if (bus_a.write_en) mem_a[bus_a.addr] <= bus_a.write_data;
        rq_a <= mem_a[bus_a.addr];
        ra_a <= bus_a.addr;
    end
    assign bus_a.read_data = (rq_a & ~stuck0[ra_a]) ^ flip[ra_a];

    // RAM model b: combinational read
    logic [7:0] mem_b [8];
    always @(posedge clk) begin
        if (bus_b.write_en) mem_b[bus_b.addr] <= bus_b.write_data;
    end
    assign bus_b.read_data = mem_b[bus_b.addr];

    int checks   = 0;
    int failures = 0;

    task automatic clear_faults();
        for (int i = 0; i < 8; i++) begin
            stuck0[i] = 8'h00;
            flip[i]   = 8'h00;
        end
    endtask

    // Pulse start on DUT a and count cycles until done; optionally re-pulse start mid-run or in the done cycle
    task automatic run_a(input int glitch, input bit start_at_done, output int lat, output logic busy1);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat     = 1;
        busy1   = busy_a;
        while (done_a !== 1'b1 && lat < 100) begin
            start_a = (lat == glitch);
            @(negedge clk);
            lat++;
        end
        start_a = start_at_done;
    endtask

    task automatic run_b(output int lat);
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat     = 1;
        while (done_b !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ((busy_a | busy_b) !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b%b want 00", busy_a, busy_b); end
        end
        checks++;
        if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done_a); end
        checks++;
        if (pass_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_pass: got %b want 0", pass_a); end
        checks++;
        if (fail_a !== 3'd0) begin failures++; $display("[TB] FAIL reset_fail_addr: got %0d want 0", fail_a); end
        checks++;
        if (err_a !== 4'd0) begin failures++; $display("[TB] FAIL reset_err: got %0d want 0", err_a); end
        checks++;
        if ({bus_a.write_en, bus_a.addr, bus_a.write_data} !== 12'h000) begin failures++; $display("[TB] FAIL reset_bus: we=%b addr=%0d wdata=%h want 0", bus_a.write_en, bus_a.addr, bus_a.write_data); end
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        int   lat;
        logic busy1;
        logic [7:0] exp_mem;
        clear_faults();
        run_a(-1, 1'b0, lat, busy1);
        checks++;
        if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL clean_busy_cycle1: got %b want 1", busy1); end
        checks++;
        if (lat !== LAT_A) begin failures++; $display("[TB] FAIL clean_latency: got %0d want %0d", lat, LAT_A); end
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL clean_busy_at_done: got %b want 0", busy_a); end
        checks++;
        if ({pass_a, err_a, fail_a} !== {1'b1, 4'd0, 3'd0}) begin failures++; $display("[TB] FAIL clean_result: got pass=%b err=%0d fail=%0d want 1/0/0", pass_a, err_a, fail_a); end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL clean_done_width: got %b want 0", done_a); end
        checks++;
        if (pass_a !== 1'b1) begin failures++; $display("[TB] FAIL clean_pass_hold: got %b want 1", pass_a); end
        for (int i = 0; i < 8; i++) begin
`ifdef RAM_BIST_INV_PASS_EN
            exp_mem = ~write_tbl[i];
`else
            exp_mem = write_tbl[i];
`endif
            checks++;
            if (mem_a[i] !== exp_mem) begin failures++; $display("[TB] FAIL clean_mem[%0d]: got %h want %h", i, mem_a[i], exp_mem); end
        end
    endtask

    task automatic test_stuck_bit();
        int   lat;
        logic busy1;
        clear_faults();
        stuck0[3] = 8'h01;
        run_a(-1, 1'b0, lat, busy1);
        checks++;
        if ({pass_a, err_a, fail_a} !== {PASS_BIT0, ERR_BIT0, FAIL_BIT0}) begin failures++; $display("[TB] FAIL stuck_bit0: got pass=%b err=%0d fail=%0d want %b/%0d/%0d", pass_a, err_a, fail_a, PASS_BIT0, ERR_BIT0, FAIL_BIT0); end
        stuck0[3] = 8'h02;
        run_a(-1, 1'b0, lat, busy1);
        checks++;
        if ({pass_a, err_a, fail_a} !== {1'b0, 4'd1, 3'd3}) begin failures++; $display("[TB] FAIL stuck_bit1: got pass=%b err=%0d fail=%0d want 0/1/3", pass_a, err_a, fail_a); end
        clear_faults();
    endtask

    task automatic test_multi_fault();
        int   lat;
        logic busy1;
        clear_faults();
        flip[2] = 8'h10;
        flip[6] = 8'h10;
        run_a(-1, 1'b0, lat, busy1);
        checks++;
        if ({pass_a, err_a, fail_a} !== {1'b0, ERR_MULTI, 3'd2}) begin failures++; $display("[TB] FAIL multi_fault: got pass=%b err=%0d fail=%0d want 0/%0d/2", pass_a, err_a, fail_a, ERR_MULTI); end
        for (int i = 0; i < 8; i++) flip[i] = 8'hFF;
        run_a(-1, 1'b0, lat, busy1);
        checks++;
        if ({pass_a, err_a, fail_a} !== {1'b0, 4'd8, 3'd0}) begin failures++; $display("[TB] FAIL saturate: got pass=%b err=%0d fail=%0d want 0/8/0", pass_a, err_a, fail_a); end
        clear_faults();
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic busy1;
        clear_faults();
        run_a(5, 1'b1, lat, busy1);
        checks++;
        if (lat !== LAT_A) begin failures++; $display("[TB] FAIL start_while_busy_latency: got %0d want %0d", lat, LAT_A); end
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if ({busy_a, done_a} !== 2'b00) begin failures++; $display("[TB] FAIL start_at_done: got busy=%b done=%b want 0/0", busy_a, done_a); end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL start_at_done_idle: got busy=%b want 0", busy_a); end
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        logic busy1;
        clear_faults();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, pass_a, err_a, fail_a} !== 10'd0) begin failures++; $display("[TB] FAIL midrun_reset_status: got busy=%b done=%b pass=%b err=%0d fail=%0d want 0", busy_a, done_a, pass_a, err_a, fail_a); end
        checks++;
        if ({bus_a.write_en, bus_a.addr, bus_a.write_data} !== 12'h000) begin failures++; $display("[TB] FAIL midrun_reset_bus: we=%b addr=%0d wdata=%h want 0", bus_a.write_en, bus_a.addr, bus_a.write_data); end
        rst = 1'b1;
        run_a(-1, 1'b0, lat, busy1);
        checks++;
        if ({lat == LAT_A, pass_a, err_a} !== {1'b1, 1'b1, 4'd0}) begin failures++; $display("[TB] FAIL after_reset_run: got lat=%0d pass=%b err=%0d want %0d/1/0", lat, pass_a, err_a, LAT_A); end
    endtask

    task automatic test_rd_lat0();
        int lat;
        logic [7:0] exp0;
        run_b(lat);
        checks++;
        if (lat !== LAT_B) begin failures++; $display("[TB] FAIL lat0_latency: got %0d want %0d", lat, LAT_B); end
        checks++;
        if ({pass_b, err_b, fail_b} !== {1'b1, 4'd0, 3'd0}) begin failures++; $display("[TB] FAIL lat0_result: got pass=%b err=%0d fail=%0d want 1/0/0", pass_b, err_b, fail_b); end
`ifdef RAM_BIST_INV_PASS_EN
        exp0 = 8'h5A;
`else
        exp0 = 8'hA5;
`endif
        checks++;
        if (mem_b[0] !== exp0) begin failures++; $display("[TB] FAIL lat0_mem0: got %h want %h", mem_b[0], exp0); end
    endtask

    initial begin
        $display("[TB] ram_bist_ctrl bench starting");
        clear_faults();
        test_reset();
        test_clean();
        test_stuck_bit();
        test_multi_fault();
        test_back_to_back();
        test_reset_mid_run();
        test_rd_lat0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Initiator side of the single-port RAM interface (clk, write_en, addr, write_data, READ_DATA). It drives an 8-entry x 8-bit RAM through a write-then-readback self-test.
- On a start pulse it fills every address with a known pattern, reads each address back and compares it against the expected value. It then reports pass/fail, the first failing address and an error count.
- Sits beside the RAM in lab designs. Used for board bring-up and as the stimulus source for the RAM itself.

Parameters:
- AW, 3, address width; depth = 2**AW.
- DW, 8, data width.
- SEED, 8'hA5, base pattern; expected(a) = SEED ^ zero-extended a.
- RD_LAT, 1, RAM read latency in cycles, from addr valid to read data valid; legal values 0 or 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
- start  in  1  one-cycle request; sampled only in IDLE.
- ram_write_en  out  1  connects to RAM write_en.
- ram_addr  out  AW  connects to RAM addr.
- ram_write_data  out  DW  connects to RAM write_data.
- ram_read_data  in  DW  connects to RAM READ_DATA.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  result; valid from done, held until the next start.
- fail_addr  out  AW  first mismatching address; 0 if none.
- err_count  out  AW+1  number of mismatches, saturating at 2**AW.

Behaviour:
- Reset: state=IDLE; ram_write_en=0, ram_addr=0, ram_write_data=0, busy=0, done=0, pass=0, fail_addr=0, err_count=0. All outputs are registered.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE, start=1: next cycle WRITE. On entry: addr=0, busy=1; err_count, fail_addr and pass are cleared.
- WRITE: each cycle ram_write_en=1, ram_write_data=expected(addr), addr increments. After addr 2**AW-1 is written: next cycle READ, addr=0, write_en=0.
- READ: each cycle one address is issued and addr increments. The expected value is pipelined RD_LAT stages alongside it. After the last address: DRAIN if RD_LAT=1, else DONE directly.
- Compare: compare-valid asserts RD_LAT cycles after each read issue. On mismatch:
  - err_count increments, saturating.
  - fail_addr is captured only on the first mismatch of the run.
- DRAIN: one cycle that completes the final compare.
- DONE: done=1 for exactly 1 cycle, busy=0, pass=(err_count==0) including the final compare result; then IDLE.
- Latency, start to done: 2*2**AW + RD_LAT + 1 cycles, which is 18 for the defaults.
- start while busy: ignored, no restart.
- start in the same cycle as done: ignored; start is sampled again next cycle in IDLE.
- Reset mid-run: abort on the same edge; all outputs return to reset values; the RAM contents are left as is.
- Address counter: AW+1 bits internally; terminal detect on the low AW bits all-ones. There is no wrap-around beyond depth.

Optional Feature:
- Macro: RAM_BIST_INV_PASS_EN.
- Defined: after the first READ pass, a second WRITE/READ pass runs with expected(a) = ~(SEED ^ a). This toggles every bit.
  - err_count and fail_addr accumulate across both passes.
  - fail_addr reports the first failure in time.
  - Latency becomes 2*(2*2**AW) + RD_LAT + 1, which is 34 for the defaults.
- Undefined: single pass only; no inverted-pattern logic is synthesised.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with start=1 -> all outputs 0, busy never asserts.
- Clean run, defaults, behavioural RAM with RD_LAT=1, start pulse -> writes addr0=8'hA5, addr1=8'hA4, ... addr7=8'hA2. done pulses 18 cycles after start; pass=1, err_count=0, fail_addr=0.
- Stuck bit: RAM model forces bit0=0 at addr 3 (expected 8'hA6, so no error there); then force bit1=0 at addr 3 -> pass=0, err_count=1, fail_addr=3.
- Multiple faults: corrupt the reads of addr 2 and addr 6 -> err_count=2, fail_addr=2. Saturation: corrupt all 8 addresses -> err_count=8.
- Protocol edges:
  - start pulsed in cycle 5 of a run -> ignored, done still arrives at cycle 18.
  - rst=0 asserted at cycle 10 -> all outputs 0 on the next edge.
  - A later start runs cleanly to pass=1.
- RD_LAT=0 with a combinational-read RAM -> done 17 cycles after start, pass=1. With RAM_BIST_INV_PASS_EN defined and defaults -> done at cycle 34, and the second pass writes addr0=8'h5A.
